sensor_cond: RTL and testbench

- Input-conditioning stage directly upstream of the warehouse sequencing FSM (fsm2).
- Takes raw, asynchronous, bouncy presence-sensor lines (S1, S2 and more) and produces synchronized, debounced levels for the FSM.
- Also produces one-cycle rise/fall event pulses per channel.
- Counts rejected glitches for diagnostics.

---
 rtl/sensor_cond_pkg.sv | 18 +
 rtl/sensor_cond_deb.sv | 62 ++++++
 rtl/sensor_cond.sv | 56 +++++
 tb/tb_sensor_cond.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sensor_cond_pkg.sv
// Shared constants for the sensor conditioning stage: default sizing,
// channel index names and the debounce counter width helper.
package sensor_cond_pkg;

    localparam int NCH_DEF        = 2;
    localparam int DEB_CYCLES_DEF = 4;
    localparam int CNT_W_DEF      = 8;

    // Channel indices of the two presence sensors feeding the sequencer
    localparam int CH_S1 = 0;
    localparam int CH_S2 = 1;

    // Debounce counter width; a single-cycle debounce still needs one bit
    function automatic int deb_cnt_w(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/sensor_cond_deb.sv
// Single-channel conditioner: two-flop synchronizer, debounce counter,
// debounced level with rise/fall pulses, and an aborted-attempt event.
module sensor_deb
    import sensor_cond_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s_raw,
    output logic s_clean,
    output logic s_rise,
    output logic s_fall,
    output logic glitch_ev
);

    localparam int CW = deb_cnt_w(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] cnt;
    logic          mismatch;

    assign mismatch = sync_p1 ^ s_clean;

    // The synchronized input fell back to the accepted level before the
    // attempt completed; driven from registers only, so no input-to-output path.
    assign glitch_ev = !mismatch && (cnt != '0);

    // Synchronize, count persistence of a new level, accept and pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= '0;
            s_clean <= 1'b0;
            s_rise  <= 1'b0;
            s_fall  <= 1'b0;
        end else begin
            // --- stage p0/p1: metastability synchronizer ---
            sync_p0 <= s_raw;
            sync_p1 <= sync_p0;
            // --- debounce stage: operates on sync_p1 only ---
            s_rise  <= 1'b0;
            s_fall  <= 1'b0;
            if (mismatch) begin
                if (cnt == CNT_LAST) begin
                    s_clean <= sync_p1;
                    cnt     <= '0;
                    s_rise  <= sync_p1;
                    s_fall  <= !sync_p1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else if (cnt != '0) begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/sensor_cond.sv
// Input conditioning ahead of the sequencing FSM: one debouncer per sensor
// line plus a shared saturating counter of rejected glitches.
module sensor_cond
    import sensor_cond_pkg::*;
#(
    parameter int NCH        = NCH_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   s_raw,
    input  logic             glitch_clr,
    output logic [NCH-1:0]   s_clean,
    output logic [NCH-1:0]   s_rise,
    output logic [NCH-1:0]   s_fall,
    output logic [CNT_W-1:0] glitch_cnt
);

    logic [NCH-1:0] glitch_ev;
    logic           glitch_any;

    // Saturating increment: holds at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        sensor_deb #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk       (clk),
            .rst_n     (rst_n),
            .s_raw     (s_raw[i]),
            .s_clean   (s_clean[i]),
            .s_rise    (s_rise[i]),
            .s_fall    (s_fall[i]),
            .glitch_ev (glitch_ev[i])
        );
    end

    // Simultaneous glitches on several channels count as one event
    assign glitch_any = |glitch_ev;

    // Diagnostic glitch counter; clear wins over a coincident glitch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            glitch_cnt <= '0;
        end else if (glitch_clr) begin
            glitch_cnt <= '0;
        end else if (glitch_any) begin
            glitch_cnt <= sat_inc(glitch_cnt);
        end
    end

endmodule

// File: tb/tb_sensor_cond.sv
// Directed bench for sensor_cond with a behavioural reference model that is
// compared against the outputs on every cycle, plus literal spot checks.
module tb_sensor_cond;
    import sensor_cond_pkg::*;

    localparam int NCH    = 2;
    localparam int DEB    = 4;
    localparam int CNT_W  = 8;
    localparam int SATMAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NCH-1:0]   s_raw;
    logic             glitch_clr;
    logic [NCH-1:0]   s_clean;
    logic [NCH-1:0]   s_rise;
    logic [NCH-1:0]   s_fall;
    logic [CNT_W-1:0] glitch_cnt;

    int total = 0;
    int bad   = 0;

    sensor_cond #(
        .NCH        (NCH),
        .DEB_CYCLES (DEB),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_raw      (s_raw),
        .glitch_clr (glitch_clr),
        .s_clean    (s_clean),
        .s_rise     (s_rise),
        .s_fall     (s_fall),
        .glitch_cnt (glitch_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: raw samples pass through a two-deep delay queue; a
    // channel accepts a new level once it has disagreed with the accepted
    // level for DEB consecutive edges, and an interrupted run is a glitch.
    logic [NCH-1:0] rawq[$] = '{2'b00, 2'b00};
    logic [NCH-1:0] m_clean = '0;
    logic [NCH-1:0] m_rise  = '0;
    logic [NCH-1:0] m_fall  = '0;
    int             m_gcnt  = 0;
    int             run[NCH] = '{0, 0};

    always @(posedge clk) begin
        logic [NCH-1:0] sv;
        bit any_g;
        if (!rst_n) begin
            rawq    = '{2'b00, 2'b00};
            m_clean = '0;
            m_rise  = '0;
            m_fall  = '0;
            m_gcnt  = 0;
            for (int c = 0; c < NCH; c++) run[c] = 0;
        end else begin
            sv = rawq[0];
            rawq.push_back(s_raw);
            void'(rawq.pop_front());
            any_g  = 1'b0;
            m_rise = '0;
            m_fall = '0;
            for (int c = 0; c < NCH; c++) begin
                if (sv[c] != m_clean[c]) begin
                    run[c] = run[c] + 1;
                    if (run[c] == DEB) begin
                        m_clean[c] = sv[c];
                        run[c]     = 0;
                        if (sv[c]) m_rise[c] = 1'b1;
                        else       m_fall[c] = 1'b1;
                    end
                end else if (run[c] > 0) begin
                    run[c] = 0;
                    any_g  = 1'b1;
                end
            end
            if (glitch_clr)                    m_gcnt = 0;
            else if (any_g && m_gcnt < SATMAX) m_gcnt = m_gcnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and compare all outputs to the model
    task automatic tick();
        @(negedge clk);
        chk("model_clean", 32'(s_clean), 32'(m_clean));
        chk("model_rise", 32'(s_rise), 32'(m_rise));
        chk("model_fall", 32'(s_fall), 32'(m_fall));
        chk("model_gcnt", 32'(glitch_cnt), 32'(m_gcnt));
    endtask

    initial begin
        rst_n      = 1'b0;
        s_raw      = 2'b11;
        glitch_clr = 1'b0;

        // Reset held three edges with both sensors high
        repeat (3) tick();
        chk("rst_clean", 32'(s_clean), 32'h0);
        chk("rst_rise", 32'(s_rise), 32'h0);
        chk("rst_fall", 32'(s_fall), 32'h0);
        chk("rst_gcnt", 32'(glitch_cnt), 32'h0);
        rst_n = 1'b1;
        repeat (5) tick();
        chk("rel_clean_early", 32'(s_clean), 32'h0);
        tick();
        chk("rel_clean", 32'(s_clean), 32'h3);
        chk("rel_rise", 32'(s_rise), 32'h3);
        tick();
        chk("rel_rise_end", 32'(s_rise), 32'h0);
        s_raw = 2'b00;
        repeat (8) tick();
        chk("idle_clean", 32'(s_clean), 32'h0);

        // Clean step on S1
        s_raw[CH_S1] = 1'b1;
        repeat (5) tick();
        chk("step_clean_early", 32'(s_clean), 32'h0);
        tick();
        chk("step_clean", 32'(s_clean), 32'h1);
        chk("step_rise", 32'(s_rise), 32'h1);
        chk("step_fall", 32'(s_fall), 32'h0);
        chk("step_gcnt", 32'(glitch_cnt), 32'h0);
        tick();
        chk("step_rise_end", 32'(s_rise), 32'h0);
        s_raw = 2'b00;
        repeat (8) tick();

        // Two-cycle bounce on S2 is rejected and counted
        s_raw[CH_S2] = 1'b1;
        repeat (2) tick();
        s_raw = 2'b00;
        repeat (6) tick();
        chk("bounce_clean", 32'(s_clean), 32'h0);
        chk("bounce_gcnt", 32'(glitch_cnt), 32'h1);

        // Both channels fall together
        s_raw = 2'b11;
        repeat (8) tick();
        chk("sim_high", 32'(s_clean), 32'h3);
        s_raw = 2'b00;
        repeat (5) tick();
        chk("sim_fall_early", 32'(s_fall), 32'h0);
        tick();
        chk("sim_fall", 32'(s_fall), 32'h3);
        chk("sim_fall_clean", 32'(s_clean), 32'h0);
        repeat (4) tick();

        // Both channels glitch in the same cycle: one count
        s_raw = 2'b11;
        repeat (2) tick();
        s_raw = 2'b00;
        repeat (6) tick();
        chk("sim_glitch_gcnt", 32'(glitch_cnt), 32'h2);

        // Saturation after 300 bursts
        for (int b = 0; b < 300; b++) begin
            s_raw = 2'b01;
            repeat (2) tick();
            s_raw = 2'b00;
            repeat (4) tick();
        end
        chk("sat_gcnt", 32'(glitch_cnt), 32'(SATMAX));

        // Clear asserted at the very edge a glitch is detected
        s_raw = 2'b01;
        repeat (2) tick();
        s_raw = 2'b00;
        repeat (2) tick();
        glitch_clr = 1'b1;
        tick();
        glitch_clr = 1'b0;
        chk("clr_gcnt", 32'(glitch_cnt), 32'h0);
        repeat (3) tick();
        chk("clr_hold", 32'(glitch_cnt), 32'h0);

        // Reset at the third counting edge discards the attempt
        s_raw = 2'b01;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_clean", 32'(s_clean), 32'h0);
        chk("mid_rst_rise", 32'(s_rise), 32'h0);
        chk("mid_rst_gcnt", 32'(glitch_cnt), 32'h0);
        repeat (5) tick();
        chk("mid_rel_early", 32'(s_clean), 32'h0);
        chk("mid_rel_gcnt", 32'(glitch_cnt), 32'h0);
        tick();
        chk("mid_rel_clean", 32'(s_clean), 32'h1);
        chk("mid_rel_rise", 32'(s_rise), 32'h1);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
